// File: rtl/uart_rx_fifo.sv
// Buffered UART receiver: 8N1 serial input, bytes into a first-word fall-through FIFO, valid/ready output.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx_fifo #(
    parameter int BIT_PERIOD = 1250,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_pin,
    output logic [7:0]                    data,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int CW = $clog2(BIT_PERIOD);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_PERIOD / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    // Two-flop synchronizer; resets to the idle line level so no false start is seen.
    logic rx_meta_q, rx_sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rx_meta_q <= rx_pin;
            rx_sync_q <= rx_meta_q;
        end
    end

    logic rxs;
    assign rxs = rx_sync_q;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            push;
    logic            frame_d;
    logic            parity_d;
    logic            bit_done;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
`endif

    assign bit_done = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        frame_d  = 1'b0;
        parity_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    par_bad_d = ^{shift_q, rxs};
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    // A bad stop bit outranks a parity mismatch: one pulse per frame.
                    if (!rxs) begin
                        frame_d = 1'b1;
                        state_d = S_BRK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_d = 1'b1;
`endif
                    end else begin
                        push = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BRK: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // FIFO: pointers carry one extra bit so count = wr - rd covers 0..FIFO_DEPTH.
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        pop, full, wr_en;
    logic        frame_err_q, parity_err_q, overrun_q;

    assign count = wr_q - rd_q;
    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = valid && ready;
    assign wr_en = push && (!full || pop);
    assign data  = valid ? mem[rd_q[AW-1:0]] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q         <= '0;
            rd_q         <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            frame_err_q  <= frame_d;
            parity_err_q <= parity_d;
            overrun_q    <= push && full && !pop;
        end
    end

    // NOTE: storage has no reset; empty pointers and the valid-gated data output hide stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= shift_q;
    end

    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based byte model checked every cycle,
// directed scenarios followed by randomized frames with random consumer backpressure.
module tb_uart_rx_fifo;

    localparam int BP    = 16;
    localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY = 1'b1;
    localparam int NB     = 10;
`else
    localparam bit PARITY = 1'b0;
    localparam int NB     = 9;
`endif
    // Edges from driving the start bit to the edge that commits the byte:
    // 2 synchronizer edges, 1 to leave IDLE, then the stop-sample cycle ends BP/2 + NB*BP later.
    localparam int PUSH_LAT = 3 + BP / 2 + NB * BP;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       rx_pin = 1'b1;
    logic       ready  = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [3:0] count;
    logic       frame_err, parity_err, overrun;

    uart_rx_fifo #(.BIT_PERIOD(BP), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_pin     (rx_pin),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .count      (count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_PUSH, EV_FRAME, EV_PARITY} ev_kind_t;
    typedef struct {
        int         edge_n;
        ev_kind_t   kind;
        logic [7:0] b;
    } ev_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] model_q[$];
    ev_t        ev_q[$];
    bit         exp_fe, exp_pe, exp_ov;
    int         fe_seen = 0, pe_seen = 0, ov_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: frame outcomes land on their commit edge; pops follow valid&&ready at each edge.
    always @(posedge clk) begin
        bit  pop;
        int  psize;
        ev_t e;
        cyc++;
        exp_fe = 1'b0;
        exp_pe = 1'b0;
        exp_ov = 1'b0;
        if (!rst_n) begin
            model_q.delete();
            ev_q.delete();
        end else begin
            psize = model_q.size();
            pop   = ready && (psize != 0);
            if (pop) void'(model_q.pop_front());
            if (ev_q.size() != 0 && ev_q[0].edge_n == cyc) begin
                e = ev_q.pop_front();
                case (e.kind)
                    EV_PUSH: begin
                        if (psize == DEPTH && !pop) exp_ov = 1'b1;
                        else model_q.push_back(e.b);
                    end
                    EV_FRAME:  exp_fe = 1'b1;
                    EV_PARITY: exp_pe = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("valid", 32'(valid), 32'(model_q.size() != 0));
        check("count", 32'(count), 32'(model_q.size()));
        if (model_q.size() != 0) check("data", 32'(data), 32'(model_q[0]));
        check("frame_err", 32'(frame_err), 32'(exp_fe));
        check("parity_err", 32'(parity_err), 32'(exp_pe));
        check("overrun", 32'(overrun), 32'(exp_ov));
        fe_seen += int'(frame_err);
        pe_seen += int'(parity_err);
        ov_seen += int'(overrun);
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic hold(input logic v, input int n);
        rx_pin = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop1();
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
        ev_t e;
        e.edge_n = cyc + PUSH_LAT;
        e.b      = b;
        e.kind   = stop_ok ? EV_PUSH : EV_FRAME;
        if (PARITY && stop_ok && par_flip) e.kind = EV_PARITY;
        ev_q.push_back(e);
        hold(1'b0, BP);
        for (int i = 0; i < 8; i++) hold(b[i], BP);
        if (PARITY) hold((^b) ^ par_flip, BP);
        if (stop_ok) begin
            hold(1'b1, BP);
        end else begin
            hold(1'b0, 3 * BP);
            hold(1'b1, BP);
        end
    endtask

    initial begin
        int         fe0, ov0;
        logic [7:0] b7e;
        logic [7:0] rb;
        bit         rok, rflip;
        bit         rdone;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset valid", 32'(valid), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset data", 32'(data), 32'd0);
        idle(4);

        // 1: single byte, then one-cycle pop
        send_frame(8'h55, 1'b1, 1'b0);
        check("t1 valid", 32'(valid), 32'd1);
        check("t1 data", 32'(data), 32'h55);
        check("t1 count", 32'(count), 32'd1);
        pop1();
        check("t1 valid after pop", 32'(valid), 32'd0);
        check("t1 count after pop", 32'(count), 32'd0);

        // 2: fill past capacity with ready low
        ov0 = ov_seen;
        for (int i = 0; i < 9; i++) send_frame(8'(8'h31 + i), 1'b1, 1'b0);
        check("t2 count full", 32'(count), 32'd8);
        check("t2 overrun pulses", 32'(ov_seen - ov0), 32'd1);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2 pop order", 32'(data), 32'(8'h31 + i));
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
        check("t2 drained", 32'(count), 32'd0);

        // 3: bad stop bit with held-low line, then recovery
        fe0 = fe_seen;
        send_frame(8'hA5, 1'b0, 1'b0);
        check("t3 frame_err pulses", 32'(fe_seen - fe0), 32'd1);
        check("t3 count", 32'(count), 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0);
        check("t3 next byte", 32'(data), 32'h0F);
        pop1();

        // 4: short glitch on the idle line
        fe0 = fe_seen;
        hold(1'b0, 4);
        hold(1'b1, 2 * BP);
        check("t4 no byte", 32'(valid), 32'd0);
        check("t4 no frame_err", 32'(fe_seen - fe0), 32'd0);
        send_frame(8'hC3, 1'b1, 1'b0);
        check("t4 next byte", 32'(data), 32'hC3);
        pop1();

        // 5: asynchronous reset during bit 4, with a byte already queued
        send_frame(8'h11, 1'b1, 1'b0);
        b7e = 8'h7E;
        hold(1'b0, BP);
        for (int i = 0; i < 4; i++) hold(b7e[i], BP);
        hold(b7e[4], BP / 2);
        #2 rst_n = 1'b0;
        model_q.delete();
        ev_q.delete();
        exp_fe = 1'b0;
        exp_pe = 1'b0;
        exp_ov = 1'b0;
        #1;
        check("t5 async valid", 32'(valid), 32'd0);
        check("t5 async count", 32'(count), 32'd0);
        check("t5 async data", 32'(data), 32'd0);
        check("t5 async pulses", 32'({frame_err, parity_err, overrun}), 32'd0);
        rx_pin = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        send_frame(8'h81, 1'b1, 1'b0);
        check("t5 byte after reset", 32'(data), 32'h81);
        check("t5 count after reset", 32'(count), 32'd1);
        pop1();

`ifdef UART_RX_PARITY_EN
        // 6: parity mismatch discards the byte; correct parity delivers it
        fe0 = pe_seen;
        send_frame(8'h03, 1'b1, 1'b1);
        check("t6 parity_err pulses", 32'(pe_seen - fe0), 32'd1);
        check("t6 no push", 32'(count), 32'd0);
        send_frame(8'h03, 1'b1, 1'b0);
        check("t6 good parity", 32'(data), 32'h03);
        pop1();
`endif

        // Randomized frames with random consumer backpressure
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    rb    = 8'($urandom);
                    rok   = ($urandom_range(0, 7) != 0);
                    rflip = ($urandom_range(0, 3) == 0);
                    send_frame(rb, rok, rflip);
                    idle($urandom_range(0, 20));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    ready = 1'($urandom_range(0, 1));
                end
            end
        join
        ready = 1'b1;
        idle(DEPTH + 2);
        ready = 1'b0;
        check("random drained", 32'(count), 32'd0);
`ifndef UART_RX_PARITY_EN
        check("parity_err never set", 32'(pe_seen), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
